lutram_fifo_ctrl: RTL and testbench
===================================

LUTRAM_FIFO_CTRL -- requirements
Module: lutram_fifo_ctrl

Interface
- REQ-001: The block SHALL have parameter SINGLE_ENTRY_WIDTH_IN_BITS, default 64, which is the entry width in bits.
- REQ-002: The block SHALL have parameter NUM_SET, default 64, which is the RAM depth and SHALL be a power of 2.
- REQ-003: The block SHALL have parameter SET_PTR_WIDTH_IN_BITS, default $clog2(NUM_SET), which is the RAM address width.
- REQ-004: The block SHALL have parameter WRITE_MASK_LEN, default SINGLE_ENTRY_WIDTH_IN_BITS / `BYTE_LEN_IN_BITS, which is the byte-lane count.
- REQ-005: Port clk_in, input, 1 bit, SHALL be the single clock; all state SHALL change on its rising edge.
- REQ-006: Port reset_n_in, input, 1 bit, SHALL be the reset, asynchronous and active-low.
- REQ-007: Port request_valid_in, input, 1 bit, SHALL indicate that an enqueue entry is offered.
- REQ-008: Port request_in, input, SINGLE_ENTRY_WIDTH_IN_BITS, SHALL carry the enqueue data.
- REQ-009: Port request_ready_out, output, 1 bit, SHALL indicate that the block can accept an enqueue.
- REQ-010: Port issue_valid_out, output, 1 bit, SHALL indicate that the head entry is presented.
- REQ-011: Port issue_out, output, SINGLE_ENTRY_WIDTH_IN_BITS, SHALL carry the head data.
- REQ-012: Port issue_ack_in, input, 1 bit, SHALL indicate that the consumer takes the head entry.
- REQ-013: Port occupancy_out, output, SET_PTR_WIDTH_IN_BITS+2 bits, SHALL give the total number of entries held.
- REQ-014: Port ram_write_access_en_out, output, 1 bit, SHALL be the RAM write-port enable.
- REQ-015: Port ram_write_en_out, output, WRITE_MASK_LEN, SHALL be the RAM byte-write enables.
- REQ-016: Port ram_write_set_addr_out, output, SET_PTR_WIDTH_IN_BITS, SHALL be the RAM write address.
- REQ-017: Port ram_write_data_out, output, SINGLE_ENTRY_WIDTH_IN_BITS, SHALL be the RAM write data.
- REQ-018: Port ram_read_access_en_out, output, 1 bit, SHALL be the RAM read-port enable.
- REQ-019: Port ram_read_set_addr_out, output, SET_PTR_WIDTH_IN_BITS, SHALL be the RAM read address.
- REQ-020: Port ram_read_data_in, input, SINGLE_ENTRY_WIDTH_IN_BITS, SHALL be the RAM read data, registered with 1-cycle latency and forced to zero when read access is disabled.

Function
- REQ-021: The block SHALL be a FIFO controller that drives an external dual-port LUTRAM (ReadFirst mode), with write/read set pointers (wr_ptr, rd_ptr), ram_count (0..NUM_SET), an inflight flag, and a 2-entry output buffer (buf_count 0..2).
- REQ-022: request_ready_out SHALL equal (ram_count != NUM_SET), combinationally from state only.
- REQ-023: When push = request_valid_in & request_ready_out, the block SHALL in the same cycle drive ram_write_access_en_out=1, ram_write_en_out=all ones, ram_write_set_addr_out=wr_ptr and ram_write_data_out=request_in, and SHALL increment wr_ptr modulo NUM_SET.
- REQ-024: When push=0, ram_write_access_en_out and ram_write_en_out SHALL be 0.
- REQ-025: pop SHALL be defined as issue_valid_out & issue_ack_in.
- REQ-026: A read SHALL be issued when ram_count != 0 and (buf_count + inflight - pop) < 2, by driving ram_read_access_en_out=1 and ram_read_set_addr_out=rd_ptr; rd_ptr SHALL then increment modulo NUM_SET and inflight SHALL be set to 1 next cycle.
- REQ-027: When no read is issued, ram_read_access_en_out SHALL be 0 and inflight SHALL be cleared next cycle.
- REQ-028: ram_count SHALL become ram_count + push - read each cycle, and ram_count SHALL NOT wrap.
- REQ-029: When inflight=1, ram_read_data_in SHALL be written into the output buffer behind existing entries; when inflight=0, ram_read_data_in SHALL be ignored.
- REQ-030: issue_valid_out SHALL equal (buf_count != 0), and issue_out SHALL present the oldest buffer entry; on pop, the next entry SHALL shift to head in the same edge.
- REQ-031: A simultaneous pop and capture SHALL keep buf_count unchanged and preserve ordering.
- REQ-032: issue_out SHALL hold stable while issue_valid_out=1 and issue_ack_in=0.
- REQ-033: issue_ack_in while issue_valid_out=0 SHALL be ignored.
- REQ-034: Write and read to the same set SHALL never occur in one cycle; the ram_count guards guarantee this.
- REQ-035: Latency SHALL be: an enqueue accepted at cycle T into an empty FIFO produces issue_valid_out=1 at T+3 (read at T+1, RAM data at T+2, buffered at T+3).
- REQ-036: Sustained throughput SHALL be 1 push and 1 pop per cycle with no bubbles once the output buffer is primed.
- REQ-037: occupancy_out SHALL equal ram_count + inflight + buf_count, with a maximum of NUM_SET+2.

Reset
- REQ-038: While reset_n_in=0, asynchronously, the block SHALL clear wr_ptr, rd_ptr, ram_count, inflight and buf_count to 0.
- REQ-039: While reset_n_in=0, the block SHALL drive issue_valid_out=0, issue_out=0, occupancy_out=0 and all ram_*_out=0.
- REQ-040: While reset_n_in=0, request_ready_out SHALL be 1 (combinational from state, per REQ-022).
- REQ-041: A reset mid-operation SHALL discard all contents, including an in-flight read.
- REQ-042: RAM contents SHALL NOT be cleared by reset and SHALL NOT be relied upon after reset.

Verification
- REQ-043: Empty FIFO, push 0xA5 at T -> issue_valid_out=1 with issue_out=0xA5 at T+3, and occupancy_out=1 during T+1..T+3.
- REQ-044: Push 0..NUM_SET+1 with ack held 0 -> request_ready_out=0 once ram_count=NUM_SET, occupancy_out=NUM_SET+2, and no RAM write while not ready.
- REQ-045: Continuous push/pop of an incrementing pattern for 4*NUM_SET cycles -> in-order data, one pop per cycle after priming, and pointers wrap correctly.
- REQ-046: Random valid/ack patterns against a reference queue model -> no loss, no duplication, and issue_out stable while stalled.
- REQ-047: reset_n_in pulsed low mid-stream with inflight=1 -> outputs 0 immediately; after release, the first new push is returned, not stale data.
- REQ-048: Assertion checks -> never a same-cycle RAM read and write to the same set; ram_read_access_en_out=0 whenever ram_count=0.

Source files
------------

// File: rtl/lutram_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for lutram_fifo_ctrl.
// The FIFO takes the slave modport; the driving side takes master.
interface lutram_fifo_ctrl_if #(
    parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64
);
    logic                                  request_valid_in;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in;
    logic                                  request_ready_out;
    logic                                  issue_valid_out;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] issue_out;
    logic                                  issue_ack_in;

    modport master (
        output request_valid_in, request_in, issue_ack_in,
        input  request_ready_out, issue_valid_out, issue_out
    );

    modport slave (
        input  request_valid_in, request_in, issue_ack_in,
        output request_ready_out, issue_valid_out, issue_out
    );
endinterface

// File: rtl/lutram_fifo_ctrl.sv
// FIFO controller for an external dual-port read-first LUTRAM with a 1-cycle
// registered read, fronted by a 2-entry output buffer for bubble-free issue.
`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module lutram_fifo_ctrl #(
    parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int unsigned NUM_SET                    = 64,
    parameter int unsigned SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
    parameter int unsigned WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / `BYTE_LEN_IN_BITS
) (
    input  logic                                  clk_in,
    input  logic                                  reset_n_in,
    lutram_fifo_ctrl_if.slave                     fifo_if,
    output logic [SET_PTR_WIDTH_IN_BITS+1:0]      occupancy_out,
    output logic                                  ram_write_access_en_out,
    output logic [WRITE_MASK_LEN-1:0]             ram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]      ram_write_set_addr_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] ram_write_data_out,
    output logic                                  ram_read_access_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]      ram_read_set_addr_out,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] ram_read_data_in
);
    localparam int unsigned CNT_W = SET_PTR_WIDTH_IN_BITS + 1;
    localparam int unsigned OCC_W = SET_PTR_WIDTH_IN_BITS + 2;
    localparam logic [CNT_W-1:0]                 FULL_COUNT = CNT_W'(NUM_SET);
    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] PTR_ONE    = SET_PTR_WIDTH_IN_BITS'(1);

    logic [SET_PTR_WIDTH_IN_BITS-1:0]      wr_ptr;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]      rd_ptr;
    logic [CNT_W-1:0]                      ram_count;
    logic                                  inflight;
    logic [1:0]                            buf_count;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] buf_head;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] buf_tail;

    logic       ready;
    logic       push;
    logic       pop;
    logic       rd_issue;
    logic [2:0] buf_pending;

    always_comb begin
        ready       = (ram_count != FULL_COUNT);
        push        = fifo_if.request_valid_in & ready;
        pop         = (buf_count != 2'd0) & fifo_if.issue_ack_in;
        // Slots the buffer will need after this edge: held + landing - leaving.
        buf_pending = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
        rd_issue    = (ram_count != '0) && (buf_pending < 3'd2);
    end

    // Write port is gated by reset so a valid held during reset never reaches the RAM.
    always_comb begin
        ram_write_access_en_out = push & reset_n_in;
        ram_write_en_out        = {WRITE_MASK_LEN{ram_write_access_en_out}};
        ram_write_set_addr_out  = ram_write_access_en_out ? wr_ptr : '0;
        ram_write_data_out      = ram_write_access_en_out ? fifo_if.request_in : '0;
        ram_read_access_en_out  = rd_issue;
        ram_read_set_addr_out   = rd_issue ? rd_ptr : '0;
    end

    always_comb begin
        fifo_if.request_ready_out = ready;
        fifo_if.issue_valid_out   = (buf_count != 2'd0);
        fifo_if.issue_out         = buf_head;
        occupancy_out             = {1'b0, ram_count} + OCC_W'(inflight) + OCC_W'(buf_count);
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            inflight  <= 1'b0;
            buf_count <= '0;
            buf_head  <= '0;
            buf_tail  <= '0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_issue) rd_ptr <= rd_ptr + PTR_ONE;
            inflight  <= rd_issue;
            ram_count <= ram_count + CNT_W'(push) - CNT_W'(rd_issue);

            unique case ({pop, inflight})
                2'b11: begin
                    if (buf_count == 2'd2) begin
                        buf_head <= buf_tail;
                        buf_tail <= ram_read_data_in;
                    end else begin
                        buf_head <= ram_read_data_in;
                    end
                end
                2'b10: begin
                    buf_head  <= buf_tail;
                    buf_count <= buf_count - 2'd1;
                end
                2'b01: begin
                    if (buf_count == 2'd0) buf_head <= ram_read_data_in;
                    else                   buf_tail <= ram_read_data_in;
                    buf_count <= buf_count + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lutram_fifo_ctrl.sv
// Bench for lutram_fifo_ctrl: directed vector table, then fill, stream,
// random and mid-stream-reset sequences against a read-first LUTRAM model.
module tb_lutram_fifo_ctrl;
    localparam int unsigned W  = 32;
    localparam int unsigned NS = 8;
    localparam int unsigned PW = 3;
    localparam int unsigned ML = 4;

    logic clk_in = 1'b0;
    logic reset_n_in;
    always #5 clk_in = ~clk_in;

    lutram_fifo_ctrl_if #(.SINGLE_ENTRY_WIDTH_IN_BITS(W)) fifo_if ();

    logic [PW+1:0] occupancy_out;
    logic          ram_write_access_en_out;
    logic [ML-1:0] ram_write_en_out;
    logic [PW-1:0] ram_write_set_addr_out;
    logic [W-1:0]  ram_write_data_out;
    logic          ram_read_access_en_out;
    logic [PW-1:0] ram_read_set_addr_out;
    logic [W-1:0]  ram_read_data_in;

    lutram_fifo_ctrl #(
        .SINGLE_ENTRY_WIDTH_IN_BITS(W),
        .NUM_SET(NS),
        .SET_PTR_WIDTH_IN_BITS(PW),
        .WRITE_MASK_LEN(ML)
    ) dut (
        .clk_in(clk_in),
        .reset_n_in(reset_n_in),
        .fifo_if(fifo_if),
        .occupancy_out(occupancy_out),
        .ram_write_access_en_out(ram_write_access_en_out),
        .ram_write_en_out(ram_write_en_out),
        .ram_write_set_addr_out(ram_write_set_addr_out),
        .ram_write_data_out(ram_write_data_out),
        .ram_read_access_en_out(ram_read_access_en_out),
        .ram_read_set_addr_out(ram_read_set_addr_out),
        .ram_read_data_in(ram_read_data_in)
    );

    // Read-first dual-port RAM, registered read, zero output when not reading.
    logic [W-1:0] mem [NS];
    always @(posedge clk_in) begin
        if (ram_write_access_en_out)
            for (int unsigned b = 0; b < ML; b++)
                if (ram_write_en_out[b])
                    mem[ram_write_set_addr_out][b*8 +: 8] <= ram_write_data_out[b*8 +: 8];
        ram_read_data_in <= ram_read_access_en_out ? mem[ram_read_set_addr_out] : '0;
    end

    typedef struct {
        logic          v;
        logic [W-1:0]  d;
        logic          a;
        logic          e_rdy;
        logic          e_iv;
        logic [W-1:0]  e_issue;
        logic [PW+1:0] e_occ;
        logic          e_wr;
        logic          e_rd;
    } vec_t;

    vec_t         vecs [15];
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] q [$];
    int           ram_model;
    logic         prev_stall;
    logic [W-1:0] prev_issue;
    int           pops;
    int           accepts;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic a);
        fifo_if.request_valid_in = v;
        fifo_if.request_in       = d;
        fifo_if.issue_ack_in     = a;
    endtask

    // Called at the negedge: protocol checks plus scoreboard update.
    task automatic sample();
        logic [W-1:0] exp_d;
        if (ram_write_access_en_out && ram_read_access_en_out)
            chk("rw_same_set", 64'(ram_write_set_addr_out == ram_read_set_addr_out), 64'd0);
        if (ram_read_access_en_out)
            chk("read_when_empty", 64'(ram_model > 0), 64'd1);
        if (!fifo_if.request_ready_out)
            chk("write_when_full", 64'(ram_write_access_en_out), 64'd0);
        if (fifo_if.request_valid_in && fifo_if.request_ready_out) begin
            chk("wr_mask", 64'(ram_write_en_out), 64'hF);
            chk("wr_data", 64'(ram_write_data_out), 64'(fifo_if.request_in));
        end
        ram_model += int'(ram_write_access_en_out) - int'(ram_read_access_en_out);
        if (prev_stall)
            chk("issue_stable", 64'(fifo_if.issue_out), 64'(prev_issue));
        if (fifo_if.issue_valid_out && fifo_if.issue_ack_in) begin
            chk("pop_model_nonempty", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                exp_d = q.pop_front();
                chk("pop_data", 64'(fifo_if.issue_out), 64'(exp_d));
            end
            pops++;
        end
        if (fifo_if.request_valid_in && fifo_if.request_ready_out) begin
            q.push_back(fifo_if.request_in);
            accepts++;
        end
        prev_stall = fifo_if.issue_valid_out && !fifo_if.issue_ack_in;
        prev_issue = fifo_if.issue_out;
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d, input logic a);
        drive(v, d, a);
        @(negedge clk_in);
        sample();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_model();
        q.delete();
        ram_model  = 0;
        prev_stall = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(fifo_if.request_ready_out), 64'd1);
        chk({tag, "_ivalid"}, 64'(fifo_if.issue_valid_out), 64'd0);
        chk({tag, "_issue"}, 64'(fifo_if.issue_out), 64'd0);
        chk({tag, "_occ"}, 64'(occupancy_out), 64'd0);
        chk({tag, "_we"}, 64'({ram_write_access_en_out, ram_write_en_out}), 64'd0);
        chk({tag, "_waddr"}, 64'(ram_write_set_addr_out), 64'd0);
        chk({tag, "_wdata"}, 64'(ram_write_data_out), 64'd0);
        chk({tag, "_re"}, 64'(ram_read_access_en_out), 64'd0);
        chk({tag, "_raddr"}, 64'(ram_read_set_addr_out), 64'd0);
    endtask

    initial begin
        int bubbles;
        int acc0;

        //         v     d        a     rdy   iv    issue    occ   wr    rd
        vecs[0]  = '{1'b1, 32'hA5, 1'b0, 1'b1, 1'b0, 32'h00, 5'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 5'd1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 5'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'hA5, 5'd1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA5, 5'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 32'h00, 5'd0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 32'h00, 5'd1, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 32'h00, 5'd2, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h11, 5'd3, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h11, 5'd3, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h11, 5'd3, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h22, 5'd2, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h33, 5'd1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 1'b0};

        pops    = 0;
        accepts = 0;
        clear_model();

        // Reset with a live request and ack on the bus.
        reset_n_in = 1'b0;
        drive(1'b1, 32'hDEADBEEF, 1'b1);
        #12;
        chk_reset_outputs("rst");
        @(posedge clk_in);
        #1;
        reset_n_in = 1'b1;
        drive(1'b0, '0, 1'b0);

        // Directed vector table: single-entry latency, then a 3-deep burst.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].a);
            @(negedge clk_in);
            chk($sformatf("vec%0d_ready", i), 64'(fifo_if.request_ready_out), 64'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_ivalid", i), 64'(fifo_if.issue_valid_out), 64'(vecs[i].e_iv));
            if (vecs[i].e_iv)
                chk($sformatf("vec%0d_issue", i), 64'(fifo_if.issue_out), 64'(vecs[i].e_issue));
            chk($sformatf("vec%0d_occ", i), 64'(occupancy_out), 64'(vecs[i].e_occ));
            chk($sformatf("vec%0d_wr", i), 64'(ram_write_access_en_out), 64'(vecs[i].e_wr));
            chk($sformatf("vec%0d_rd", i), 64'(ram_read_access_en_out), 64'(vecs[i].e_rd));
            sample();
            @(posedge clk_in);
            #1;
        end

        // Fill with ack held low: NUM_SET in RAM plus 2 buffered.
        acc0 = accepts;
        for (int k = 0; k < 2*NS + 4; k++) cycle(1'b1, W'(100 + k), 1'b0);
        @(negedge clk_in);
        chk("fill_accepted", 64'(accepts - acc0), 64'(NS + 2));
        chk("fill_occ", 64'(occupancy_out), 64'(NS + 2));
        chk("fill_ready", 64'(fifo_if.request_ready_out), 64'd0);
        @(posedge clk_in);
        #1;
        for (int k = 0; k < 2*NS + 4; k++) cycle(1'b0, '0, 1'b1);
        chk("fill_drained_model", 64'(q.size()), 64'd0);
        chk("fill_drained_occ", 64'(occupancy_out), 64'd0);

        // Continuous push/pop: one pop per cycle from the third cycle on.
        bubbles = 0;
        acc0    = pops;
        for (int k = 0; k < 4*int'(NS); k++) begin
            drive(1'b1, W'(1000 + k), 1'b1);
            @(negedge clk_in);
            if (k >= 3 && !fifo_if.issue_valid_out) bubbles++;
            sample();
            @(posedge clk_in);
            #1;
        end
        chk("stream_bubbles", 64'(bubbles), 64'd0);
        chk("stream_pops", 64'(pops - acc0), 64'(4*NS - 3));
        for (int k = 0; k < 8; k++) cycle(1'b0, '0, 1'b1);
        chk("stream_drained_model", 64'(q.size()), 64'd0);

        // Random valid/ack traffic against the queue model.
        for (int k = 0; k < 400; k++)
            cycle($urandom_range(0, 99) < 60, W'($urandom), $urandom_range(0, 99) < 50);
        for (int k = 0; k < 2*NS + 6; k++) cycle(1'b0, '0, 1'b1);
        chk("rand_drained_model", 64'(q.size()), 64'd0);
        chk("rand_drained_occ", 64'(occupancy_out), 64'd0);

        // Reset while a RAM read is in flight; stale data must not reappear.
        cycle(1'b1, 32'h0BAD0BAD, 1'b0);
        cycle(1'b0, '0, 1'b0);
        drive(1'b1, 32'h0BAD0BAD, 1'b1);
        reset_n_in = 1'b0;
        #2;
        chk_reset_outputs("midrst");
        clear_model();
        @(posedge clk_in);
        #1;
        reset_n_in = 1'b1;
        cycle(1'b1, 32'h5A, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1);
        @(negedge clk_in);
        chk("post_rst_ivalid", 64'(fifo_if.issue_valid_out), 64'd1);
        chk("post_rst_issue", 64'(fifo_if.issue_out), 64'h5A);
        sample();
        @(posedge clk_in);
        #1;
        cycle(1'b0, '0, 1'b0);
        chk("post_rst_empty", 64'(occupancy_out), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
